// File: rtl/switch_debounce_toggle.sv
// Four-switch conditioner: two-flop synchroniser, per-switch debounce counter,
// one-cycle release pulse and an LED that toggles on every debounced release.
module switch_debounce_toggle #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Sw_Db,
  output logic [3:0] o_Release,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  localparam int unsigned NumSw = 4;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

  logic [NumSw-1:0] sw_raw;

  logic [NumSw-1:0] sync1_q, sync1_d;
  logic [NumSw-1:0] sync2_q, sync2_d;
  logic [NumSw-1:0] db_q, db_d;
  logic [NumSw-1:0] rel_q, rel_d;
  logic [NumSw-1:0] led_q, led_d;
  logic [NumSw-1:0][CntW-1:0] cnt_q, cnt_d;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    for (int n = 0; n < NumSw; n++) begin
      if (sync2_q[n] == db_q[n]) begin
        // Any return to the accepted level throws away partial progress.
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CntMax) begin
        db_d[n]  = sync2_q[n];
        cnt_d[n] = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
    // Only a 1->0 transition of the debounced level counts as a release.
    rel_d = db_q & ~db_d;
    led_d = led_q ^ rel_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rel_q   <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      rel_q   <= rel_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Sw_Db   = db_q;
  assign o_Release = rel_q;
  assign o_LED_1   = led_q[0];
  assign o_LED_2   = led_q[1];
  assign o_LED_3   = led_q[2];
  assign o_LED_4   = led_q[3];

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Directed and randomised checks of switch_debounce_toggle against a sliding-window
// reference: a level is accepted once DL consecutive synchronised samples disagree with it.
module tb_switch_debounce_toggle;

  localparam int unsigned DL = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_drv;
  logic [3:0] sw_db;
  logic [3:0] rel;
  logic       led1, led2, led3, led4;

  int n_vectors;
  int n_miscompares;

  // Reference state: raw samples per switch, newest at index 0.
  logic       hist [4][DL+2];
  logic [3:0] m_db;
  logic [3:0] m_rel;
  logic [3:0] m_led;

  switch_debounce_toggle #(
    .DEBOUNCE_LIMIT(DL)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Switch_1(sw_drv[0]),
    .i_Switch_2(sw_drv[1]),
    .i_Switch_3(sw_drv[2]),
    .i_Switch_4(sw_drv[3]),
    .o_Sw_Db   (sw_db),
    .o_Release (rel),
    .o_LED_1   (led1),
    .o_LED_2   (led2),
    .o_LED_3   (led3),
    .o_LED_4   (led4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < DL + 2; k++) hist[n][k] = 1'b0;
    m_db  = '0;
    m_rel = '0;
    m_led = '0;
  endtask

  // The synchronised value seen at an edge is the raw sample from two edges
  // earlier; a change is accepted when the last DL such values all differ.
  task automatic model_edge(input logic [3:0] sw);
    logic [3:0] nd;
    logic       all_diff;
    for (int n = 0; n < 4; n++) begin
      for (int k = DL + 1; k > 0; k--) hist[n][k] = hist[n][k-1];
      hist[n][0] = sw[n];
      all_diff = 1'b1;
      for (int k = 2; k < DL + 2; k++)
        if (hist[n][k] == m_db[n]) all_diff = 1'b0;
      nd[n] = all_diff ? ~m_db[n] : m_db[n];
    end
    m_rel = m_db & ~nd;
    m_led = m_led ^ m_rel;
    m_db  = nd;
  endtask

  task automatic check_outputs(input string ctx);
    check_val({ctx, ".db"},  sw_db, m_db);
    check_val({ctx, ".rel"}, rel, m_rel);
    check_val({ctx, ".led"}, {led4, led3, led2, led1}, m_led);
  endtask

  task automatic step(input logic [3:0] sw, input string ctx);
    sw_drv = sw;
    @(posedge clk);
    model_edge(sw);
    #1;
    check_outputs(ctx);
  endtask

  task automatic hold(input logic [3:0] sw, input int edges, input string ctx);
    for (int i = 0; i < edges; i++) step(sw, ctx);
  endtask

  // Assert reset mid-cycle, confirm outputs clear without a clock edge,
  // keep it low across an edge, then release away from the edge.
  task automatic pulse_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({ctx, ".async"});
    @(posedge clk);
    #1;
    check_outputs({ctx, ".held"});
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int hold_left [4];
    logic [3:0] cur;

    n_vectors     = 0;
    n_miscompares = 0;
    model_reset();
    sw_drv = 4'b1111;
    rst_n  = 1'b0;

    // 1: reset with all switches pressed, then Switch_1 accepted after DL+2 edges.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs("t1.rst");
    end
    #3;
    rst_n = 1'b1;
    hold(4'b0001, DL + 1, "t1");
    check_val("t1.pre_accept", sw_db, 4'b0000);
    step(4'b0001, "t1");
    check_val("t1.accept", sw_db, 4'b0001);
    check_val("t1.led1", {3'b000, led1}, 4'b0000);

    // 2: release, then a second press and release.
    hold(4'b0000, DL + 1, "t2");
    check_val("t2.pre_release", sw_db, 4'b0001);
    step(4'b0000, "t2");
    check_val("t2.pulse", rel, 4'b0001);
    check_val("t2.led_on", {3'b000, led1}, 4'b0001);
    step(4'b0000, "t2");
    check_val("t2.pulse_gone", rel, 4'b0000);
    hold(4'b0001, DL + 2, "t2b");
    hold(4'b0000, DL + 2, "t2b");
    check_val("t2.led_off", {3'b000, led1}, 4'b0000);

    // 3: bounce on Switch_2 never reaches acceptance.
    hold(4'b0010, 3, "t3");
    hold(4'b0000, 1, "t3");
    hold(4'b0010, 3, "t3");
    hold(4'b0000, DL + 2, "t3");
    check_val("t3.led2", {2'b00, led2, 1'b0}, 4'b0000);

    // 4: all four switches released on the same cycle.
    hold(4'b1111, DL + 2, "t4");
    check_val("t4.all_db", sw_db, 4'b1111);
    hold(4'b0000, DL + 1, "t4");
    step(4'b0000, "t4");
    check_val("t4.all_pulse", rel, 4'b1111);
    check_val("t4.all_led", {led4, led3, led2, led1}, 4'b1111);

    // 5: reset while Switch_1's counter is partway, then full re-acceptance.
    hold(4'b0001, 4, "t5");
    pulse_reset("t5");
    check_val("t5.led_clear", {led4, led3, led2, led1}, 4'b0000);
    hold(4'b0001, DL + 1, "t5");
    check_val("t5.not_yet", sw_db, 4'b0000);
    step(4'b0001, "t5");
    check_val("t5.reaccept", sw_db, 4'b0001);
    hold(4'b0000, DL + 2, "t5");

    // 6: sub-cycle glitch on Switch_3 between clock edges.
    for (int i = 0; i < 3; i++) begin
      #2 sw_drv[2] = 1'b1;
      #2 sw_drv[2] = 1'b0;
      step(4'b0000, "t6");
    end
    hold(4'b0000, DL + 2, "t6");

    // Randomised: each switch holds a level for 1..2*DL edges, occasional reset.
    cur = '0;
    for (int n = 0; n < 4; n++) hold_left[n] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 4; n++) begin
        if (hold_left[n] == 0) begin
          cur[n]       = $urandom_range(1, 0) == 1;
          hold_left[n] = $urandom_range(2 * DL, 1);
        end
        hold_left[n]--;
      end
      if ($urandom_range(199, 0) == 0) pulse_reset("rnd");
      step(cur, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
